// File: rtl/risc_defs_pkg.sv
// Shared definitions for the 16-bit 5-stage RISC front end.
// Holds the opcode field layout, the opcode constants, the canonical NOP word
// and the fetch FSM state encoding used by the IF stage.
package risc_defs_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned PERF_W   = 32;

  localparam logic [OPCODE_W-1:0] OP_LDM = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_STD = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_NOT = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_NOP = 3'b101;

  // Opcode 101 with all operand fields zero: decode asserts no writes.
  localparam logic [WORD_W-1:0] NOP_WORD = 16'hA000;

  typedef enum logic {
    S_INST = 1'b0,  // fetch an opcode word
    S_IMM  = 1'b1   // fetch the immediate word of an LDM
  } fetch_state_e;

endpackage : risc_defs_pkg

// File: rtl/fetch_pc_reg.sv
// Program counter register.
// Priority: rst > redirect > hold > increment. Increment wraps modulo 2^PC_W.
// Ports:
//   clk, rst         clock, synchronous active-high reset (loads RESET_PC)
//   redirect_i       load redirect_pc_i (overrides hold)
//   redirect_pc_i    redirect target
//   hold_i           keep the current value
//   pc_o             registered PC
module fetch_pc_reg #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            hold_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Next PC selection.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (!hold_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule : fetch_pc_reg

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Reads a combinational instruction memory at the PC, assembles two-word LDM
// instructions (opcode word + immediate word) and presents {inst, imm, pc,
// valid} to decode. Supports stall (hold everything) and flush (redirect PC,
// drop any half-fetched LDM, insert a NOP bubble).
// Optional build macro FETCH_PERF_CNT_EN adds issued-instruction and bubble
// counters.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   stall_i          hold PC, FSM and IF/ID register
//   flush_i          redirect PC to flush_pc_i and kill in-flight fetch
//   flush_pc_i       redirect target
//   imem_addr_o      instruction memory address (= PC)
//   imem_rdata_i     instruction memory data (combinational)
//   ifid_inst_o      instruction word to decode
//   ifid_imm_o       immediate (0 for one-word instructions)
//   ifid_pc_o        address of the instruction's first word
//   ifid_valid_o     IF/ID holds a real instruction
//   perf_insts_o     (FETCH_PERF_CNT_EN) instructions issued to decode
//   perf_bubbles_o   (FETCH_PERF_CNT_EN) bubbles issued to decode
module fetch_stage
  import risc_defs_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INST_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [PC_W-1:0]   flush_pc_i,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [INST_W-1:0] ifid_inst_o,
  output logic [INST_W-1:0] ifid_imm_o,
  output logic [PC_W-1:0]   ifid_pc_o,
  output logic              ifid_valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_insts_o,
  output logic [PERF_W-1:0] perf_bubbles_o
`endif
);

  localparam logic [INST_W-1:0] NOP_INST = INST_W'(NOP_WORD);

  fetch_state_e state_q, state_d;

  logic [INST_W-1:0] pend_inst_q, pend_inst_d;
  logic [PC_W-1:0]   pend_pc_q,   pend_pc_d;
  logic [INST_W-1:0] ifid_inst_q, ifid_inst_d;
  logic [INST_W-1:0] ifid_imm_q,  ifid_imm_d;
  logic [PC_W-1:0]   ifid_pc_q,   ifid_pc_d;
  logic              ifid_valid_q, ifid_valid_d;

  logic [PC_W-1:0]     pc;
  logic [OPCODE_W-1:0] opcode;
  logic                load_en;

  assign opcode  = imem_rdata_i[INST_W-1 -: OPCODE_W];
  // Flush always loads the IF/ID register, even under stall.
  assign load_en = flush_i | ~stall_i;

  fetch_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (flush_i),
    .redirect_pc_i (flush_pc_i),
    .hold_i        (stall_i),
    .pc_o          (pc)
  );

  // Fetch FSM next-state and IF/ID register inputs.
  always_comb begin
    state_d      = state_q;
    pend_inst_d  = pend_inst_q;
    pend_pc_d    = pend_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_imm_d   = ifid_imm_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;

    if (flush_i) begin
      state_d      = S_INST;
      pend_inst_d  = '0;
      pend_pc_d    = '0;
      ifid_inst_d  = NOP_INST;
      ifid_imm_d   = '0;
      ifid_valid_d = 1'b0;
    end else if (!stall_i) begin
      case (state_q)
        S_INST: begin
          if (opcode == OP_LDM) begin
            // First LDM word: park it and emit one bubble.
            pend_inst_d  = imem_rdata_i;
            pend_pc_d    = pc;
            ifid_inst_d  = NOP_INST;
            ifid_valid_d = 1'b0;
            state_d      = S_IMM;
          end else begin
            ifid_inst_d  = imem_rdata_i;
            ifid_imm_d   = '0;
            ifid_pc_d    = pc;
            ifid_valid_d = 1'b1;
          end
        end
        S_IMM: begin
          // rdata is the immediate here, never an opcode.
          ifid_inst_d  = pend_inst_q;
          ifid_imm_d   = imem_rdata_i;
          ifid_pc_d    = pend_pc_q;
          ifid_valid_d = 1'b1;
          state_d      = S_INST;
        end
      endcase
    end
  end

  // State and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INST;
      pend_inst_q  <= '0;
      pend_pc_q    <= '0;
      ifid_inst_q  <= NOP_INST;
      ifid_imm_q   <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_inst_q  <= pend_inst_d;
      pend_pc_q    <= pend_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_imm_q   <= ifid_imm_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_addr_o  = pc;
  assign ifid_inst_o  = ifid_inst_q;
  assign ifid_imm_o   = ifid_imm_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_valid_o = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [PERF_W-1:0] perf_insts_q,   perf_insts_d;
  logic [PERF_W-1:0] perf_bubbles_q, perf_bubbles_d;

  // Count what was loaded into IF/ID on every non-stalled cycle.
  always_comb begin
    perf_insts_d   = perf_insts_q;
    perf_bubbles_d = perf_bubbles_q;
    if (load_en) begin
      if (ifid_valid_d) begin
        perf_insts_d = perf_insts_q + PERF_W'(1);
      end else begin
        perf_bubbles_d = perf_bubbles_q + PERF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_insts_q   <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_insts_q   <= perf_insts_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_insts_o   = perf_insts_q;
  assign perf_bubbles_o = perf_bubbles_q;
`else
  logic unused_load_en;
  assign unused_load_en = load_en;
`endif

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/flush/reset traffic over random memory, checked against an
// instruction-stream reference model.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'hA000;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [15:0] flush_pc_i;
  logic [15:0] imem_addr_o;
  logic [15:0] imem_rdata_i;
  logic [15:0] ifid_inst_o;
  logic [15:0] ifid_imm_o;
  logic [15:0] ifid_pc_o;
  logic        ifid_valid_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_insts_o;
  logic [31:0] perf_bubbles_o;
`endif

  logic [15:0] mem [0:65535];
  assign imem_rdata_i = mem[imem_addr_o];

  fetch_stage #(
    .PC_W     (16),
    .INST_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .ifid_inst_o  (ifid_inst_o),
    .ifid_imm_o   (ifid_imm_o),
    .ifid_pc_o    (ifid_pc_o),
    .ifid_valid_o (ifid_valid_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_insts_o   (perf_insts_o),
    .perf_bubbles_o (perf_bubbles_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the fetch unit walks the instruction stream; an LDM
  // consumes two consecutive words and costs one bubble before it issues.
  logic [15:0] m_pc;
  bit          m_half_ldm;     // first LDM word taken, immediate still due
  logic [15:0] m_ldm_word;
  logic [15:0] m_ldm_pc;
  logic [15:0] m_inst, m_imm, m_ifpc;
  bit          m_valid;
  logic [31:0] m_insts, m_bubbles;

  task automatic model_step(input bit r, input bit st, input bit fl, input logic [15:0] fpc);
    logic [15:0] w;
    w = mem[m_pc];
    if (r) begin
      m_pc = 16'h0000; m_half_ldm = 0; m_ldm_word = 0; m_ldm_pc = 0;
      m_inst = NOP; m_imm = 0; m_ifpc = 0; m_valid = 0;
      m_insts = 0; m_bubbles = 0;
    end else if (fl) begin
      m_pc = fpc; m_half_ldm = 0;
      m_inst = NOP; m_imm = 0; m_valid = 0;
      m_bubbles = m_bubbles + 1;
    end else if (st) begin
      // nothing moves
    end else if (m_half_ldm) begin
      m_inst = m_ldm_word; m_imm = w; m_ifpc = m_ldm_pc; m_valid = 1;
      m_half_ldm = 0; m_pc = m_pc + 16'd1;
      m_insts = m_insts + 1;
    end else if (w[15:13] == 3'b001) begin
      m_ldm_word = w; m_ldm_pc = m_pc; m_half_ldm = 1; m_pc = m_pc + 16'd1;
      m_inst = NOP; m_valid = 0;
      m_bubbles = m_bubbles + 1;
    end else begin
      m_inst = w; m_imm = 0; m_ifpc = m_pc; m_valid = 1; m_pc = m_pc + 16'd1;
      m_insts = m_insts + 1;
    end
  endtask

  // One clock: drive at negedge, advance the model, compare after posedge.
  task automatic cycle(input bit r, input bit st, input bit fl, input logic [15:0] fpc);
    @(negedge clk);
    rst = r; stall_i = st; flush_i = fl; flush_pc_i = fpc;
    model_step(r, st, fl, fpc);
    @(posedge clk);
    #1;
    check("imem_addr", 32'(imem_addr_o), 32'(m_pc));
    check("ifid_inst", 32'(ifid_inst_o), 32'(m_inst));
    check("ifid_imm", 32'(ifid_imm_o), 32'(m_imm));
    check("ifid_pc", 32'(ifid_pc_o), 32'(m_ifpc));
    check("ifid_valid", 32'(ifid_valid_o), 32'(m_valid));
`ifdef FETCH_PERF_CNT_EN
    check("perf_insts", perf_insts_o, m_insts);
    check("perf_bubbles", perf_bubbles_o, m_bubbles);
`endif
  endtask

  task automatic fill_nop();
    for (int a = 0; a < 65536; a++) mem[a] = NOP;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = '0;
    m_pc = 0; m_half_ldm = 0; m_ldm_word = 0; m_ldm_pc = 0;
    m_inst = NOP; m_imm = 0; m_ifpc = 0; m_valid = 0; m_insts = 0; m_bubbles = 0;

    // Straight-line code followed by an LDM.
    fill_nop();
    mem[0] = 16'h6123; mem[1] = 16'h8456; mem[2] = 16'hA000; mem[3] = 16'h6000;
    mem[4] = 16'h2400; mem[5] = 16'h00AB; mem[6] = 16'h6000;
    cycle(1, 0, 0, 0);
    check("rst_inst", 32'(ifid_inst_o), 32'h0000A000);
    check("rst_valid", 32'(ifid_valid_o), 32'd0);
    check("rst_pc", 32'(imem_addr_o), 32'd0);
    cycle(0, 0, 0, 0);
    check("tp_add", 32'(ifid_inst_o), 32'h00006123);
    cycle(0, 0, 0, 0);
    check("tp_not_pc", 32'(ifid_pc_o), 32'd1);
    cycle(0, 0, 0, 0);
    check("tp_nop_valid", 32'(ifid_valid_o), 32'd1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("tp_ldm_bubble", 32'(ifid_inst_o), 32'h0000A000);
    check("tp_ldm_bubble_v", 32'(ifid_valid_o), 32'd0);
    cycle(0, 0, 0, 0);
    check("tp_ldm_inst", 32'(ifid_inst_o), 32'h00002400);
    check("tp_ldm_imm", 32'(ifid_imm_o), 32'h000000AB);
    check("tp_ldm_pc", 32'(ifid_pc_o), 32'd4);
    check("tp_ldm_next", 32'(imem_addr_o), 32'd6);

    // Stall for three cycles while the immediate is due.
    cycle(1, 0, 0, 0);
    mem[0] = 16'h2400; mem[1] = 16'h00AB; mem[2] = 16'h6000;
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    check("stall_pc", 32'(imem_addr_o), 32'd1);
    cycle(0, 0, 0, 0);
    check("stall_ldm_imm", 32'(ifid_imm_o), 32'h000000AB);
    check("stall_ldm_pc", 32'(ifid_pc_o), 32'd0);

    // Flush overrides stall while an LDM is half fetched.
    cycle(1, 0, 0, 0);
    mem[32] = 16'h7777;
    cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 16'h0020);
    check("flush_pc", 32'(imem_addr_o), 32'h20);
    check("flush_inst", 32'(ifid_inst_o), 32'h0000A000);
    cycle(0, 0, 0, 0);
    check("flush_next", 32'(ifid_inst_o), 32'h00007777);

    // LDM straddling the top of the address space.
    mem[16'hFFFF] = 16'h2400; mem[0] = 16'h1234;
    cycle(0, 0, 1, 16'hFFFF);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("wrap_imm", 32'(ifid_imm_o), 32'h00001234);
    check("wrap_ifpc", 32'(ifid_pc_o), 32'h0000FFFF);
    check("wrap_pc", 32'(imem_addr_o), 32'd1);

    // Reset while an LDM is half fetched.
    mem[1] = 16'h2555;
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("rst_mid_valid", 32'(ifid_valid_o), 32'd0);
    check("rst_mid_pc", 32'(imem_addr_o), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_mid_perf", perf_insts_o | perf_bubbles_o, 32'd0);
`endif

    // Randomized traffic over random memory.
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    cycle(1, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit r, st, fl;
      r  = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 24) == 0);
      st = ($urandom_range(0, 4) == 0);
      cycle(r, st, fl, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_stage
